// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers for the parametrised synchronous FIFO.
//   log2            - ceiling log2, usable in constant expressions
//   is_pow2         - true for powers of two >= 2
//   fifo_params_ok  - elaboration-time legality check of the FIFO parameters
package sync_fifo_pkg;

  // Ceiling log2; log2(1) = 0, log2(16) = 4, log2(17) = 5.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit fifo_params_ok(input int data_w, input int depth,
                                        input int af_thresh, input int ae_thresh,
                                        input int fwft);
    return (data_w >= 1) && is_pow2(depth) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// sync_fifo_param_mem (fifo_mem): DATA_W x DEPTH register array.
//   clk    - write clock, rising edge
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index (asynchronous read)
//   rdata  - mem[raddr], combinational
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with fill count, almost
// thresholds, sticky error flags and optional first-word-fall-through read.
//   clk, rstn            - clock (rising edge), synchronous active-low reset
//   wr_en, din           - write request and data
//   rd_en                - read request (pop)
//   dout                 - read data (registered, or fall-through when FWFT=1)
//   empty, full          - occupancy extremes
//   almost_empty/full    - count <= AE_THRESH / count >= AF_THRESH
//   count                - entries stored, 0..DEPTH
//   overflow, underflow  - sticky rejected-request flags, cleared by err_clr
//   err_clr              - synchronous clear of the sticky flags
//
// Handshake: a write is taken on any rising edge where wr_en=1 and the FIFO
// is not full, or is full but a read is taken on the same edge; a read is
// taken on any rising edge where rd_en=1 and the FIFO is not empty. There is
// no ready/valid back-pressure signal beyond full/empty: a request that is
// not taken is dropped and recorded in overflow/underflow.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      din,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      dout,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [log2(DEPTH):0]   count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int IDX_W = log2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] AF_T = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_T = CNT_W'(AE_THRESH);

  if (!fifo_params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
    $error("sync_fifo_param: illegal parameter combination");
  end

  // Pointers carry one extra wrap bit above the index.
  logic [CNT_W-1:0]  wr_ptr, rd_ptr;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              rd_accept, wr_accept;
  logic [DATA_W-1:0] mem_rdata;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  // Status is decoded purely from registered pointers.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) && (wr_idx == rd_idx);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  // A read frees a slot on the same edge, so a full FIFO still takes a write
  // when it is also being read. An empty FIFO never bypasses din to dout.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + CNT_W'(1);
      if (rd_accept) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_accept) overflow <= 1'b1;
      else if (err_clr)        overflow <= 1'b0;
      if (rd_en && empty)      underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept && rstn),
    .waddr (wr_idx),
    .wdata (din),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  if (FWFT == 0) begin : g_std
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (!rstn)          dout_q <= '0;
      else if (rd_accept) dout_q <= mem_rdata;
    end
    assign dout = dout_q;
  end else begin : g_fwft
    // Head of the queue is always visible; rd_en only acknowledges it.
    assign dout = mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: one standard-mode instance and one
// FWFT instance, both DATA_W=16, DEPTH=16, AF_THRESH=14, AE_THRESH=2.
module tb_sync_fifo_param;

  localparam int W = 16;
  localparam int D = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance signals
  logic         rstn_s, wr_s, rd_s, clr_s;
  logic [W-1:0] din_s, dout_s;
  logic         empty_s, full_s, ae_s, af_s, ovf_s, unf_s;
  logic [4:0]   count_s;

  // FWFT instance signals
  logic         rstn_f, wr_f, rd_f, clr_f;
  logic [W-1:0] din_f, dout_f;
  logic         empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
  logic [4:0]   count_f;

  sync_fifo_param #(.DATA_W(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rstn(rstn_s), .wr_en(wr_s), .din(din_s), .rd_en(rd_s), .dout(dout_s),
    .empty(empty_s), .full(full_s), .almost_empty(ae_s), .almost_full(af_s),
    .count(count_s), .overflow(ovf_s), .underflow(unf_s), .err_clr(clr_s)
  );

  sync_fifo_param #(.DATA_W(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .rstn(rstn_f), .wr_en(wr_f), .din(din_f), .rd_en(rd_f), .dout(dout_f),
    .empty(empty_f), .full(full_f), .almost_empty(ae_f), .almost_full(af_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f), .err_clr(clr_f)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model_q[$];   // contents the FIFO should hold
  logic [W-1:0] exp_q[$];     // read data expected on dout after the edge
  logic [W-1:0] m_dout;       // last value standard-mode dout should show
  logic         m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status_s();
    int n;
    n = model_q.size();
    check("std_count", 32'(count_s), 32'(n));
    check("std_empty", 32'(empty_s), 32'(n == 0));
    check("std_full",  32'(full_s),  32'(n == D));
    check("std_af",    32'(af_s),    32'(n >= 14));
    check("std_ae",    32'(ae_s),    32'(n <= 2));
    check("std_ovf",   32'(ovf_s),   32'(m_ovf));
    check("std_unf",   32'(unf_s),   32'(m_unf));
    check("std_dout",  32'(dout_s),  32'(m_dout));
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_std(input int cycles);
    rstn_s = 1'b0; wr_s = 1'b0; rd_s = 1'b0; clr_s = 1'b0; din_s = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rstn_s = 1'b1;
    model_q.delete();
    exp_q.delete();
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // One clock of the standard instance; the model decides acceptance from
  // its own occupancy before the edge, then every output is compared.
  task automatic step_s(input logic wr, input logic rd, input logic clr, input logic [W-1:0] d);
    bit m_rd, m_wr;
    m_rd = rd && (model_q.size() > 0);
    m_wr = wr && ((model_q.size() < D) || m_rd);
    if (m_rd) exp_q.push_back(model_q.pop_front());
    if (m_wr) model_q.push_back(d);
    if (wr && !m_wr) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && !m_rd) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    wr_s = wr; rd_s = rd; clr_s = clr; din_s = d;
    @(posedge clk);
    #1;
    wr_s = 1'b0; rd_s = 1'b0; clr_s = 1'b0;
    if (m_rd) m_dout = exp_q.pop_front();
    check_status_s();
  endtask

  task automatic step_f(input logic wr, input logic rd, input logic [W-1:0] d);
    wr_f = wr; rd_f = rd; din_f = d;
    @(posedge clk);
    #1;
    wr_f = 1'b0; rd_f = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         wr, rd, clr;
    logic [W-1:0] din;
    int           e_count;
    logic         e_ae, e_af, e_ovf, e_unf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    logic [W-1:0] v;

    // Hand-computed from an empty FIFO (AE=2, AF=14).
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1}; // read empty
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0}; // clear
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1, 1'b1, 1'b0, 1'b0, 1'b1}; // empty + both
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0011, 2, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0022, 3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'h0033, 3, 1'b0, 1'b0, 1'b0, 1'b0}; // pops 0x1234
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1}; // error beats clear
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0};

    rstn_f = 1'b0; wr_f = 1'b0; rd_f = 1'b0; clr_f = 1'b0; din_f = '0;

    // ---- reset / idle ----
    reset_std(3);
    rstn_f = 1'b1;
    check("rst_count", 32'(count_s), 0);
    check("rst_empty", 32'(empty_s), 1);
    check("rst_full",  32'(full_s), 0);
    check("rst_ae",    32'(ae_s), 1);
    check("rst_af",    32'(af_s), 0);
    check("rst_ovf",   32'(ovf_s), 0);
    check("rst_unf",   32'(unf_s), 0);
    check("rst_dout",  32'(dout_s), 0);
    check("rst_fw_empty", 32'(empty_f), 1);

    // ---- table-driven vectors ----
    for (int i = 0; i < 11; i++) begin
      step_s(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      check($sformatf("vec%0d_count", i), 32'(count_s), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_ae", i),    32'(ae_s),    32'(vecs[i].e_ae));
      check($sformatf("vec%0d_af", i),    32'(af_s),    32'(vecs[i].e_af));
      check($sformatf("vec%0d_ovf", i),   32'(ovf_s),   32'(vecs[i].e_ovf));
      check($sformatf("vec%0d_unf", i),   32'(unf_s),   32'(vecs[i].e_unf));
    end
    // After vec2 dout must still be the reset value; vec5 popped 0x1234.
    check("vec_last_dout", 32'(dout_s), 32'h0033);

    // ---- fill / overflow / full+both / drain ----
    for (int i = 1; i <= D; i++) begin
      step_s(1'b1, 1'b0, 1'b0, W'(i));
      if (i == 13) check("af_at_13", 32'(af_s), 0);
      if (i == 14) check("af_at_14", 32'(af_s), 1);
    end
    check("full_after_16", 32'(full_s), 1);
    step_s(1'b1, 1'b0, 1'b0, 16'hDEAD);
    check("ovf_17th", 32'(ovf_s), 1);
    check("count_17th", 32'(count_s), 16);
    step_s(1'b1, 1'b1, 1'b0, 16'hBEEF);   // full + both: pops 0x0001
    check("full_both_count", 32'(count_s), 16);
    check("full_both_dout", 32'(dout_s), 32'h0001);
    for (int i = 0; i < D; i++) begin
      step_s(1'b0, 1'b1, 1'b0, '0);
      if (i == 13) check("ae_at_2", 32'(ae_s), 1);
    end
    check("drain_last_beef", 32'(dout_s), 32'hBEEF);
    check("drain_empty", 32'(empty_s), 1);
    step_s(1'b0, 1'b1, 1'b0, '0);          // read empty
    check("unf_set", 32'(unf_s), 1);
    check("ovf_still", 32'(ovf_s), 1);
    step_s(1'b0, 1'b0, 1'b1, '0);
    check("clr_ovf", 32'(ovf_s), 0);
    check("clr_unf", 32'(unf_s), 0);

    // ---- wrap-around random traffic, count held in 1..15 ----
    for (int i = 0; i < 8; i++) step_s(1'b1, 1'b0, 1'b0, W'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < 40; i++) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (model_q.size() <= 1) r = 1'b0;
      if (model_q.size() >= 15) w = 1'b0;
      step_s(w, r, 1'b0, W'($urandom_range(0, 16'hFFFF)));
    end
    n = model_q.size();
    for (int i = 0; i < n; i++) step_s(1'b0, 1'b1, 1'b0, '0);
    check("wrap_empty", 32'(empty_s), 1);
    check("wrap_sb_drained", 32'(exp_q.size()), 0);

    // ---- mid-stream reset of the standard instance ----
    for (int i = 0; i < 5; i++) step_s(1'b1, 1'b0, 1'b0, W'(16'h0100 + i));
    reset_std(1);
    check_status_s();

    // ---- FWFT instance ----
    step_f(1'b1, 1'b0, 16'hA5A5);
    check("fw_not_empty", 32'(empty_f), 0);
    check("fw_dout_fall", 32'(dout_f), 32'hA5A5);
    step_f(1'b0, 1'b0, '0);
    check("fw_dout_held", 32'(dout_f), 32'hA5A5);
    step_f(1'b0, 1'b1, '0);
    check("fw_pop_empty", 32'(empty_f), 1);
    for (int i = 0; i < 5; i++) begin
      v = W'(16'h0C00 + i);
      step_f(1'b1, 1'b0, v);
    end
    check("fw_count5", 32'(count_f), 5);
    check("fw_head", 32'(dout_f), 32'h0C00);
    step_f(1'b0, 1'b1, '0);
    check("fw_next_head", 32'(dout_f), 32'h0C01);
    check("fw_count4", 32'(count_f), 4);
    step_f(1'b1, 1'b0, 16'h0C05);
    check("fw_count5b", 32'(count_f), 5);
    rstn_f = 1'b0;
    step_f(1'b1, 1'b1, 16'hFFFF);          // requests in the reset cycle are ignored
    rstn_f = 1'b1;
    check("fw_rst_empty", 32'(empty_f), 1);
    check("fw_rst_count", 32'(count_f), 0);
    check("fw_rst_unf", 32'(unf_f), 0);
    check("fw_rst_ovf", 32'(ovf_f), 0);

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
